// File: rtl/challenge_pkg.sv
// Shared constants for the flag checker: default parameters and the flag text.
//   DEF_FLAG_LEN : default number of flag characters
//   DEF_STATE_W  : default width of the match-index register
//   FLAG_STR     : flag bytes, element [FLAG_CHARS-1] holds character 0
//   flag_char()  : character lookup by index, 7'h00 past the end of the flag
package challenge_pkg;

  localparam int unsigned FLAG_CHARS   = 49;
  localparam int unsigned DEF_FLAG_LEN = FLAG_CHARS;
  localparam int unsigned DEF_STATE_W  = 8;

  // A string literal fills a packed byte array MSB-first, so the first character
  // lands in the highest element.
  localparam logic [FLAG_CHARS-1:0][7:0] FLAG_STR =
    "pbctf{M4yb3_I_5h0u1d_1mp13m3nt_0n_as1c_n3xt_t1m3}";

  function automatic logic [6:0] flag_char(input int unsigned idx);
    logic [7:0] c;
    c = 8'h00;
    if (idx < FLAG_CHARS) begin
      c = FLAG_STR[6'(FLAG_CHARS - 1 - idx)];
    end
    return c[6:0];
  endfunction

endpackage

// File: rtl/challenge_rom.sv
// Index-to-character lookup for the flag.
//   i_idx  : match index (STATE_W bits)
//   o_char : expected 7-bit character, 7'h00 for i_idx >= FLAG_LEN
module challenge_rom
  import challenge_pkg::*;
#(
  parameter int unsigned FLAG_LEN = challenge_pkg::DEF_FLAG_LEN,
  parameter int unsigned STATE_W  = challenge_pkg::DEF_STATE_W
) (
  input  logic [STATE_W-1:0] i_idx,
  output logic [6:0]         o_char
);

  // Pure combinational table; out-of-range indices read as NUL.
  always_comb begin
    o_char = 7'h00;
    if (32'(i_idx) < FLAG_LEN) begin
      o_char = flag_char(32'(i_idx));
    end
  end

endmodule

// File: rtl/challenge.sv
// Serial flag checker: advances a match index for each correct character.
//   clk       : clock, rising edge
//   n_rst     : asynchronous active-low reset
//   en        : byte-valid strobe
//   next_byte : candidate 7-bit ASCII character
//   win       : combinational, high once the whole flag has been matched
//   state     : number of flag characters matched so far (0..FLAG_LEN)
// Build option: CHALLENGE_STRICT_EN -- a wrong character restarts matching at 0
// instead of holding the current index.
module challenge
  import challenge_pkg::*;
#(
  parameter int unsigned FLAG_LEN = challenge_pkg::DEF_FLAG_LEN,
  parameter int unsigned STATE_W  = challenge_pkg::DEF_STATE_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               en,
  input  logic [6:0]         next_byte,
  output logic               win,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [6:0]         w_exp_char;
  logic               w_done;

  challenge_rom #(
    .FLAG_LEN (FLAG_LEN),
    .STATE_W  (STATE_W)
  ) u_rom (
    .i_idx  (r_state),
    .o_char (w_exp_char)
  );

  assign w_done = (r_state == STATE_W'(FLAG_LEN));

  // Next match index; once complete the index is frozen until reset.
  always_comb begin
    w_state_nxt = r_state;
    if (en && !w_done) begin
      if (next_byte == w_exp_char) begin
        w_state_nxt = r_state + STATE_W'(1);
      end
`ifdef CHALLENGE_STRICT_EN
      else begin
        // Restart without re-checking the failing byte against character 0.
        w_state_nxt = '0;
      end
`endif
    end
  end

  // Match-index register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= '0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign state = r_state;
  assign win   = w_done;

endmodule

// File: tb/tb_challenge.sv
module tb_challenge;

  logic       clk;
  logic       n_rst;
  logic       en;
  logic [6:0] next_byte;
  logic       win;
  logic [7:0] state;

  int total;
  int bad;

  string flag = "pbctf{M4yb3_I_5h0u1d_1mp13m3nt_0n_as1c_n3xt_t1m3}";

  challenge dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .en        (en),
    .next_byte (next_byte),
    .win       (win),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One byte with en=1 for exactly one rising edge; outputs sampled #1 later.
  task automatic send(input logic [6:0] c);
    @(negedge clk);
    en        = 1'b1;
    next_byte = c;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic send_prefix(input int n);
    for (int i = 0; i < n; i++) begin
      send(7'(flag[i]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    en    = 1'b0;
    #1;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (state !== 8'd0 || win !== 1'b0) begin
      bad++;
      $display("FAIL reset: state=%0d win=%b, want state=0 win=0", state, win);
    end
  endtask

  task automatic test_prefix();
    string p = "pbctf{";
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(7'(p[i]));
      total++;
      if (state !== 8'(i + 1) || win !== 1'b0) begin
        bad++;
        $display("FAIL prefix[%0d]: state=%0d win=%b, want state=%0d win=0",
                 i, state, win, i + 1);
      end
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] exp_st;
`ifdef CHALLENGE_STRICT_EN
    exp_st = 8'd0;
`else
    exp_st = 8'd6;
`endif
    do_reset();
    send_prefix(6);
    send(7'h58);
    total++;
    if (state !== exp_st) begin
      bad++;
      $display("FAIL mismatch_X: state=%0d, want %0d", state, exp_st);
    end
    // A wrong byte equal to FLAG[0] must not count as a fresh first match.
    do_reset();
    send_prefix(6);
    send(7'h70);
    total++;
    if (state !== exp_st) begin
      bad++;
      $display("FAIL mismatch_p: state=%0d, want %0d", state, exp_st);
    end
  endtask

  task automatic test_full_flag();
    do_reset();
    send_prefix(48);
    total++;
    if (state !== 8'd48 || win !== 1'b0) begin
      bad++;
      $display("FAIL before_close: state=%0d win=%b, want state=48 win=0", state, win);
    end
    send(7'h7D);
    total++;
    if (state !== 8'd49 || win !== 1'b1) begin
      bad++;
      $display("FAIL full_flag: state=%0d win=%b, want state=49 win=1", state, win);
    end
    send(7'h61);
    total++;
    if (state !== 8'd49 || win !== 1'b1) begin
      bad++;
      $display("FAIL after_win_a: state=%0d win=%b, want state=49 win=1", state, win);
    end
    send(7'h00);
    total++;
    if (state !== 8'd49 || win !== 1'b1) begin
      bad++;
      $display("FAIL after_win_nul: state=%0d win=%b, want state=49 win=1", state, win);
    end
  endtask

  task automatic test_en_low();
    do_reset();
    send_prefix(39);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en        = 1'b0;
      // First idle cycle presents the correct next character.
      next_byte = (i == 0) ? 7'h6E : 7'($urandom_range(0, 127));
      @(posedge clk);
      #1;
      total++;
      if (state !== 8'd39) begin
        bad++;
        $display("FAIL en_low[%0d]: state=%0d, want 39", i, state);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_prefix(20);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if (state !== 8'd0 || win !== 1'b0) begin
      bad++;
      $display("FAIL async_mid: state=%0d win=%b, want state=0 win=0", state, win);
    end
    @(negedge clk);
    n_rst = 1'b1;
    send_prefix(49);
    total++;
    if (win !== 1'b1) begin
      bad++;
      $display("FAIL async_prewin: win=%b, want 1", win);
    end
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if (state !== 8'd0 || win !== 1'b0) begin
      bad++;
      $display("FAIL async_win: state=%0d win=%b, want state=0 win=0", state, win);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_sweep();
    logic [7:0] exp_st;
    for (int v = 'h20; v <= 'h7D; v++) begin
      do_reset();
      send_prefix(39);
`ifdef CHALLENGE_STRICT_EN
      exp_st = (v == 'h6E) ? 8'd40 : 8'd0;
`else
      exp_st = (v == 'h6E) ? 8'd40 : 8'd39;
`endif
      send(7'(v));
      total++;
      if (state !== exp_st) begin
        bad++;
        $display("FAIL sweep 0x%02h: state=%0d, want %0d", v, state, exp_st);
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    n_rst     = 1'b0;
    en        = 1'b0;
    next_byte = 7'h00;
    test_reset();
    test_prefix();
    test_mismatch();
    test_full_flag();
    test_en_low();
    test_async_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/challenge.md
CHALLENGE -- requirements
Module: challenge

Interface
REQ-001 Parameter FLAG_LEN, default 49: number of characters in the accepted flag string.
REQ-002 Parameter STATE_W, default 8: width of the state output; SHALL satisfy 2**STATE_W > FLAG_LEN.
REQ-003 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port n_rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port en, input, 1: byte-valid strobe; next_byte is consumed on each rising clk edge with en=1.
REQ-006 Port next_byte, input, 7: candidate 7-bit ASCII character.
REQ-007 Port win, output, 1: high when the complete flag has been entered.
REQ-008 Port state, output, STATE_W: current match index, equal to the number of flag characters matched so far (0..FLAG_LEN).

Function
REQ-009 The flag SHALL be the 49-character string "pbctf{M4yb3_I_5h0u1d_1mp13m3nt_0n_as1c_n3xt_t1m3}", index 0 = 'p', index 48 = '}'.
REQ-010 On a rising edge with en=1, state<FLAG_LEN and next_byte equal to FLAG[state][6:0], state SHALL increment by 1.
REQ-011 On a rising edge with en=1, state<FLAG_LEN and a mismatch, state SHALL hold, unless overridden by REQ-016.
REQ-012 With en=0, state SHALL hold regardless of next_byte.
REQ-013 Once state==FLAG_LEN, state SHALL hold until reset; further bytes are ignored, matching or not.
REQ-014 win SHALL be combinational (state==FLAG_LEN); it rises in the same cycle state reaches FLAG_LEN, i.e. one clock after the final '}' is sampled.
REQ-015 Latency: one clock from sampling a byte to the updated state; one byte is consumed per cycle with no stall or backpressure.

Configuration
REQ-016 Macro CHALLENGE_STRICT_EN:
- defined: a mismatch per REQ-011 SHALL force state to 0, with no re-evaluation of the failing byte against FLAG[0];
- undefined: a mismatch holds state.
- Both builds are otherwise identical.

Reset
REQ-017 n_rst=0 SHALL asynchronously force state=0 and win=0, including when asserted mid-sequence or after win.
REQ-018 After n_rst deasserts, the first rising edge with en=1 SHALL compare next_byte against FLAG[0].

Structure
REQ-019 Package challenge_pkg SHALL hold FLAG_LEN, STATE_W defaults and the flag character constant array.
REQ-020 Sub-module challenge_rom SHALL map an index (STATE_W bits) to the expected 7-bit character and return 7'h00 for indices >= FLAG_LEN; the FSM compares against its output.
REQ-021 No other sub-modules; state SHALL be a single register in challenge.

Verification
REQ-022 Reset, then feed "pbctf{" with en=1 -> state steps 1..6; win=0.
REQ-023 From state 6, feed 'X' -> state stays 6 (default build) or 0 (CHALLENGE_STRICT_EN build).
REQ-024 Feed the full 49-char flag -> state=49 and win=1 one clock after '}'; then feed 'a' -> state stays 49, win stays 1.
REQ-025 Feed the first 39 chars, then drive en=0 for 5 cycles with random next_byte -> state holds 39.
REQ-026 Assert n_rst=0 mid-cycle at state 20, and again after win -> state=0 and win=0 immediately, without waiting for a clock edge.
REQ-027 Reset, then sweep next_byte 0x20..0x7D (one trial per value, reset between trials) after prefix "pbctf{M4yb3_I_5h0u1d_1mp13m3nt_0n_as1c_" -> only 'n' (0x6E) advances state from 39 to 40.
